// File: rtl/multi_chan_req_ack_pkg.sv
// Shared types and width helpers for the multi-channel request/acknowledge concentrator.
package multi_chan_req_ack_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_e;

   // Channel index width; a single-channel build still needs one bit.
   function automatic int chan_w(input int n_chan);
      return (n_chan > 1) ? $clog2(n_chan) : 1;
   endfunction

   // Width holding 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Width holding 0..timeout_cycles inclusive.
   function automatic int to_w(input int timeout_cycles);
      return $clog2(timeout_cycles + 1);
   endfunction

endpackage

// File: rtl/multi_chan_req_ack_if.sv
// Handshake bundle between event producers / shared consumer (master) and the concentrator (slave).
interface multi_chan_req_ack_if
   import multi_chan_req_ack_pkg::*;
#(
   parameter int N_CHAN = 4,
   parameter int CHAN_W = chan_w(N_CHAN)
);
   logic [N_CHAN-1:0] vld_in;
   logic [N_CHAN-1:0] rdy_out;
   logic [N_CHAN-1:0] ovf_out;
   logic              req_out;
   logic [CHAN_W-1:0] chan_out;
   logic              ack_in;
   logic              timeout_out;

   modport master (
      output vld_in, ack_in,
      input  rdy_out, ovf_out, req_out, chan_out, timeout_out
   );

   modport slave (
      input  vld_in, ack_in,
      output rdy_out, ovf_out, req_out, chan_out, timeout_out
   );
endinterface

// File: rtl/multi_chan_req_ack_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module multi_chan_req_ack_rr_arbiter
   import multi_chan_req_ack_pkg::*;
#(
   parameter int N_CHAN = 4,
   parameter int CHAN_W = chan_w(N_CHAN)
) (
   input  logic [N_CHAN-1:0] req,
   input  logic [CHAN_W-1:0] ptr,
   output logic [CHAN_W-1:0] gnt_idx,
   output logic              any_req
);

   int idx;

   // Scan channels starting at ptr; the first pending one wins.
   always_comb begin
      idx     = 0;
      gnt_idx = '0;
      any_req = 1'b0;
      for (int off = 0; off < N_CHAN; off++) begin
         idx = (int'(ptr) + off) % N_CHAN;
         if (!any_req && req[idx]) begin
            any_req = 1'b1;
            gnt_idx = CHAN_W'(idx);
         end
      end
   end

endmodule

// File: rtl/multi_chan_req_ack.sv
// N-channel request/acknowledge concentrator with per-channel saturating event counters.
// Optional macro ACK_TIMEOUT_EN aborts a request left unacknowledged for TIMEOUT_CYCLES cycles.
//
// state | meaning
// IDLE  | no request presented; grant next pending channel at the coming edge
// REQ   | req_out high for chan_out; waiting for ack_in (or timeout)
module multi_chan_req_ack
   import multi_chan_req_ack_pkg::*;
#(
   parameter int N_CHAN         = 4,
   parameter int DEPTH          = 3,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 reset_in,
   multi_chan_req_ack_if.slave  bus
);

   localparam int CHAN_W = chan_w(N_CHAN);
   localparam int CNT_W  = cnt_w(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(N_CHAN - 1);

   if (N_CHAN < 2 || DEPTH < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("multi_chan_req_ack: illegal parameter set");
   end

   state_e            state_q, state_d;
   logic              req_q, req_d;
   logic [CHAN_W-1:0] chan_q, chan_d;
   logic [CHAN_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q [N_CHAN];
   logic [CNT_W-1:0]  cnt_d [N_CHAN];
   logic [N_CHAN-1:0] ovf_q, ovf_d;
   logic              timeout_q, timeout_d;

   logic [N_CHAN-1:0] pend;
   logic [N_CHAN-1:0] dec;
   logic [CHAN_W-1:0] gnt_idx;
   logic              any_req;
   logic              abort;
   logic              done;

   multi_chan_req_ack_rr_arbiter #(.N_CHAN(N_CHAN), .CHAN_W(CHAN_W)) u_rr_arbiter (
      .req     (pend),
      .ptr     (ptr_q),
      .gnt_idx (gnt_idx),
      .any_req (any_req)
   );

`ifdef ACK_TIMEOUT_EN
   localparam int TO_W = to_w(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   // Down-counter reloaded in IDLE; reaching zero marks the last REQ cycle allowed.
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (state_q == IDLE)
         to_cnt_d = TO_LOAD;
      else if (to_cnt_q != '0)
         to_cnt_d = to_cnt_q - 1'b1;
   end

   // Timeout counter register.
   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) to_cnt_q <= '0;
      else          to_cnt_q <= to_cnt_d;
   end

   assign abort = (state_q == REQ) && !bus.ack_in && (to_cnt_q == '0);
`else
   assign abort = 1'b0;
`endif

   assign done = (state_q == REQ) && (bus.ack_in || abort);

   // Per-channel pending flags, completion strobes and ready outputs.
   always_comb begin
      pend = '0;
      dec  = '0;
      for (int i = 0; i < N_CHAN; i++) begin
         pend[i]        = (cnt_q[i] != '0);
         dec[i]         = done && (chan_q == CHAN_W'(i));
         bus.rdy_out[i] = (cnt_q[i] != CNT_FULL);
      end
   end

   // Saturating event counters; a completion and a new pulse on one channel cancel out.
   always_comb begin
      ovf_d = ovf_q;
      for (int i = 0; i < N_CHAN; i++) begin
         cnt_d[i] = cnt_q[i];
         if (bus.vld_in[i] && !dec[i]) begin
            if (cnt_q[i] == CNT_FULL) ovf_d[i] = 1'b1;
            else                      cnt_d[i] = cnt_q[i] + 1'b1;
         end else if (!bus.vld_in[i] && dec[i]) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
         end
      end
   end

   // Request FSM next state; pointer moves past the channel just completed.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      chan_d    = chan_q;
      ptr_d     = ptr_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = REQ;
               req_d   = 1'b1;
               chan_d  = gnt_idx;
            end
         end
         REQ: begin
            if (done) begin
               state_d   = IDLE;
               req_d     = 1'b0;
               ptr_d     = (chan_q == CHAN_LAST) ? '0 : chan_q + 1'b1;
               timeout_d = !bus.ack_in;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, outputs and counters; reset discards all pending events at once.
   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         chan_q    <= '0;
         ptr_q     <= '0;
         ovf_q     <= '0;
         timeout_q <= 1'b0;
         for (int i = 0; i < N_CHAN; i++) cnt_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         chan_q    <= chan_d;
         ptr_q     <= ptr_d;
         ovf_q     <= ovf_d;
         timeout_q <= timeout_d;
         for (int i = 0; i < N_CHAN; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign bus.req_out     = req_q;
   assign bus.chan_out    = chan_q;
   assign bus.ovf_out     = ovf_q;
   assign bus.timeout_out = timeout_q;

endmodule

// File: tb/tb_multi_chan_req_ack.sv
// Randomized and directed bench for multi_chan_req_ack against a queue-count reference model.
module tb_multi_chan_req_ack;
   import multi_chan_req_ack_pkg::*;

   localparam int N_CHAN         = 4;
   localparam int DEPTH          = 3;
   localparam int TIMEOUT_CYCLES = 16;

   logic clk = 1'b0;
   logic reset_in;

   multi_chan_req_ack_if #(.N_CHAN(N_CHAN)) bus ();

   multi_chan_req_ack #(
      .N_CHAN(N_CHAN), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk      (clk),
      .reset_in (reset_in),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: pending events per channel and the presented request
   int m_cnt [N_CHAN];
   bit m_ovf [N_CHAN];
   int m_ptr;
   bit m_req;
   int m_chan;
   bit m_tmo;
   int m_wait;

   logic              obs_req;
   int                obs_chan;
   logic [N_CHAN-1:0] obs_rdy;
   logic [N_CHAN-1:0] obs_ovf;
   logic              obs_tmo;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_CHAN; i++) begin
         m_cnt[i] = 0;
         m_ovf[i] = 1'b0;
      end
      m_ptr = 0; m_req = 1'b0; m_chan = 0; m_tmo = 1'b0; m_wait = 0;
   endtask

   task automatic model_step(input logic [N_CHAN-1:0] v, input logic a);
      bit done = 1'b0;
      bit to   = 1'b0;
      int g    = -1;
      m_tmo = 1'b0;
      if (!m_req) begin
         for (int k = 0; k < N_CHAN; k++) begin
            int c = (m_ptr + k) % N_CHAN;
            if (g < 0 && m_cnt[c] > 0) g = c;
         end
      end else if (a) begin
         done = 1'b1;
      end
`ifdef ACK_TIMEOUT_EN
      else begin
         m_wait++;
         if (m_wait >= TIMEOUT_CYCLES) begin
            done = 1'b1;
            to   = 1'b1;
         end
      end
`endif
      for (int i = 0; i < N_CHAN; i++) begin
         int net = int'(v[i]) - ((done && m_chan == i) ? 1 : 0);
         if (net > 0 && m_cnt[i] == DEPTH) m_ovf[i] = 1'b1;
         else                              m_cnt[i] += net;
      end
      if (g >= 0) begin
         m_req = 1'b1; m_chan = g; m_wait = 0;
      end else if (done) begin
         m_req = 1'b0; m_ptr = (m_chan + 1) % N_CHAN; m_tmo = to;
      end
   endtask

   task automatic compare_all();
      logic [N_CHAN-1:0] e_rdy, e_ovf;
      for (int i = 0; i < N_CHAN; i++) begin
         e_rdy[i] = (m_cnt[i] < DEPTH);
         e_ovf[i] = m_ovf[i];
      end
      obs_req  = bus.req_out;
      obs_chan = int'(bus.chan_out);
      obs_rdy  = bus.rdy_out;
      obs_ovf  = bus.ovf_out;
      obs_tmo  = bus.timeout_out;
      check_val("req_out",     32'(bus.req_out),     32'(m_req));
      check_val("chan_out",    32'(bus.chan_out),    32'(m_chan));
      check_val("rdy_out",     32'(bus.rdy_out),     32'(e_rdy));
      check_val("ovf_out",     32'(bus.ovf_out),     32'(e_ovf));
      check_val("timeout_out", 32'(bus.timeout_out), 32'(m_tmo));
   endtask

   // mode 0: no ack, 1: ack held high, 2: ack only when a request is seen
   task automatic step(input logic [N_CHAN-1:0] v, input int mode);
      logic a;
      @(negedge clk);
      compare_all();
      a = (mode == 1) || (mode == 2 && obs_req);
      bus.vld_in = v;
      bus.ack_in = a;
      @(posedge clk);
      model_step(v, a);
   endtask

   task automatic serve_one(output int ch);
      ch = -1;
      for (int t = 0; t < 40; t++) begin
         step('0, 2);
         if (obs_req) begin
            ch = obs_chan;
            break;
         end
      end
      if (ch < 0) check_val("serve_wait_expired", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_in   = 1'b1;
      bus.vld_in = '0;
      bus.ack_in = 1'b0;
      @(negedge clk);
      reset_in = 1'b0;
      model_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ch;
      int pulses;
      int rate;
      logic [N_CHAN-1:0] v;

      reset_in   = 1'b1;
      bus.vld_in = '0;
      bus.ack_in = 1'b0;
      model_reset();

      // reset held: outputs stay in reset state despite vld activity
      repeat (4) begin
         @(negedge clk);
         compare_all();
         bus.vld_in = N_CHAN'($urandom);
         bus.ack_in = 1'($urandom);
      end
      @(negedge clk);
      reset_in   = 1'b0;
      bus.vld_in = '0;
      bus.ack_in = 1'b0;
      repeat (20) step('0, 1);

      // single event on channel 1, then pointer sits at 2
      do_reset();
      step(4'b0010, 0);
      step('0, 0);
      step('0, 2);
      check_val("single_req",  32'(obs_req), 32'd1);
      check_val("single_chan", 32'(obs_chan), 32'd1);
      step(4'b1010, 0);
      serve_one(ch);
      check_val("ptr_after_ack", 32'(ch), 32'd3);
      serve_one(ch);
      check_val("ptr_wrap", 32'(ch), 32'd1);

      // round robin from reset
      do_reset();
      step(4'b1111, 0);
      for (int k = 0; k < N_CHAN; k++) begin
         serve_one(ch);
         check_val("rr_seq", 32'(ch), 32'(k));
      end
      repeat (5) step('0, 2);

      // overflow on channel 2
      do_reset();
      repeat (4) step(4'b0100, 0);
      step('0, 0);
      check_val("ovf_rdy2", 32'(obs_rdy[2]), 32'd0);
      check_val("ovf_flag2", 32'(obs_ovf[2]), 32'd1);
      for (int k = 0; k < DEPTH; k++) begin
         serve_one(ch);
         check_val("ovf_drain_chan", 32'(ch), 32'd2);
      end
      repeat (10) step('0, 2);
      check_val("ovf_sticky", 32'(obs_ovf[2]), 32'd1);
      check_val("ovf_idle", 32'(obs_req), 32'd0);

      // completion and new pulse on a full channel in the same cycle
      do_reset();
      repeat (3) step(4'b0001, 0);
      step(4'b0001, 1);
      step('0, 0);
      check_val("simul_rdy0", 32'(obs_rdy[0]), 32'd0);
      check_val("simul_ovf0", 32'(obs_ovf[0]), 32'd0);

      // asynchronous reset mid-request
      do_reset();
      step(4'b0100, 0);
      step('0, 0);
      step('0, 0);
      check_val("pre_rst_req", 32'(obs_req), 32'd1);
      @(negedge clk);
      #2 reset_in = 1'b1;
      #1;
      check_val("async_rst_req",  32'(bus.req_out), 32'd0);
      check_val("async_rst_chan", 32'(bus.chan_out), 32'd0);
      @(negedge clk);
      reset_in = 1'b0;
      model_reset();
      repeat (5) step('0, 2);

`ifdef ACK_TIMEOUT_EN
      // no ack: abort after TIMEOUT_CYCLES, then the next channel is granted
      do_reset();
      step(4'b0110, 0);
      pulses = 0;
      repeat (22) begin
         step('0, 0);
         if (obs_tmo) pulses++;
      end
      step('0, 0);
      check_val("to_pulse_count", 32'(pulses), 32'd1);
      check_val("to_next_req",  32'(obs_req), 32'd1);
      check_val("to_next_chan", 32'(obs_chan), 32'd2);

      // ack on the final allowed cycle completes normally
      do_reset();
      step(4'b0001, 0);
      step('0, 0);
      repeat (TIMEOUT_CYCLES - 1) step('0, 0);
      step('0, 1);
      pulses = 0;
      repeat (5) begin
         step('0, 0);
         if (obs_tmo) pulses++;
      end
      check_val("to_ack_last", 32'(pulses), 32'd0);
`endif

      // randomized traffic with varying load
      do_reset();
      rate = 4;
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) rate = $urandom_range(1, 12);
         for (int i = 0; i < N_CHAN; i++) v[i] = ($urandom_range(0, 15) < rate);
         if ($urandom_range(0, 9) == 0) step(v, 2);
         else                           step(v, ($urandom_range(0, 2) == 0) ? 1 : 0);
      end
      step('0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
